// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream frame arbiter.
package axis_frame_arbiter_pkg;

    typedef enum logic {
        ARB,
        PASS
    } arb_state_e;

    localparam int ARB_SOF_BIT = 0;
    localparam int MAX_SRC     = 16;

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_SRC-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) idx |= 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi4s_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4s_if #(
    parameter int DATA_WIDTH = 24,
    parameter int USER_WIDTH = 1,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;

    modport master (
        output tvalid, tdata, tuser, tlast, tkeep, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tuser, tlast, tkeep, tid, tdest,
        output tready
    );
endinterface

// File: rtl/axis_rr_picker.sv
// Rotating-priority encoder: first request above the pointer wins.
module axis_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic          valid,
    output logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        // scan downward so the nearest position after pointer is written last
        for (int i = N; i >= 1; i--) begin
            int k;
            k = (int'(pointer) + i) % N;
            if (req[k]) begin
                valid     = 1'b1;
                index     = IW'(k);
                onehot    = '0;
                onehot[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI4-Stream video output.
module axis_frame_arbiter
    import axis_frame_arbiter_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 24,
    parameter int USER_WIDTH = 1,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int IDX_WIDTH  = $clog2(N_SRC)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_SRC-1:0]            enable_i,
    input  logic [N_SRC-1:0]            s_tvalid_i,
    output logic [N_SRC-1:0]            s_tready_o,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [N_SRC*USER_WIDTH-1:0] s_tuser_i,
    input  logic [N_SRC-1:0]            s_tlast_i,
    axi4s_if.master                     m_axis,
    output logic [N_SRC-1:0]            grant_o,
    output logic                        busy_o,
    output logic [31:0]                 frame_cnt_o,
    output logic [15:0]                 drop_cnt_o
);
    arb_state_e            state;
    logic [N_SRC-1:0]      grant;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [31:0]           frame_cnt;
    logic [15:0]           drop_cnt;

    logic [N_SRC-1:0]      req;
    logic [N_SRC-1:0]      flush;
    logic                  pick_valid;
    logic [IDX_WIDTH-1:0]  pick_idx;
    logic [N_SRC-1:0]      pick_oh;
    logic [IDX_WIDTH-1:0]  g;
    logic                  pass;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [USER_WIDTH-1:0] out_user;
    logic                  out_last;
    logic [4:0]            n_flush;
    logic [16:0]           drop_sum;
    logic [15:0]           drop_next;

    assign pass = (state == PASS);
    assign g    = IDX_WIDTH'(onehot_to_idx(MAX_SRC'(grant)));

    always_comb begin
        req     = '0;
        flush   = '0;
        n_flush = '0;
        for (int k = 0; k < N_SRC; k++) begin
            req[k]   = enable_i[k] & s_tvalid_i[k]
                     & s_tuser_i[k*USER_WIDTH+ARB_SOF_BIT];
            flush[k] = enable_i[k] & s_tvalid_i[k] & ~grant[k]
                     & ~s_tuser_i[k*USER_WIDTH+ARB_SOF_BIT];
            n_flush  = n_flush + 5'(flush[k]);
        end
    end

    axis_rr_picker #(
        .N  (N_SRC),
        .IW (IDX_WIDTH)
    ) u_picker (
        .req     (req),
        .pointer (ptr),
        .valid   (pick_valid),
        .index   (pick_idx),
        .onehot  (pick_oh)
    );

    // granted source is muxed straight through for zero-latency forwarding
    always_comb begin
        int gi;
        gi        = int'(g);
        out_valid = pass & s_tvalid_i[gi];
        out_data  = s_tdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        out_user  = s_tuser_i[gi*USER_WIDTH +: USER_WIDTH];
        out_last  = s_tlast_i[gi];
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tuser  = out_user;
    assign m_axis.tlast  = out_last;
    assign m_axis.tkeep  = '1;
    assign m_axis.tid    = '0;
    assign m_axis.tdest  = '0;

    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            s_tready_o[k] = ~rst_i
                          & (flush[k] | (pass & grant[k] & m_axis.tready));
        end
    end

    assign drop_sum  = {1'b0, drop_cnt} + 17'(n_flush);
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ARB;
            grant     <= '0;
            ptr       <= IDX_WIDTH'(N_SRC - 1);
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            drop_cnt <= drop_next;
            unique case (state)
                ARB: begin
                    if (pick_valid) begin
                        state <= PASS;
                        grant <= pick_oh;
                        ptr   <= pick_idx;
                    end
                end
                PASS: begin
                    if (out_valid && m_axis.tready && out_last) begin
                        frame_cnt <= frame_cnt + 32'd1;
                        state     <= ARB;
                        grant     <= '0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign grant_o     = grant;
    assign busy_o      = pass;
    assign frame_cnt_o = frame_cnt;
    assign drop_cnt_o  = drop_cnt;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed scoreboard bench for axis_frame_arbiter.
module tb_axis_frame_arbiter;
    localparam int N  = 4;
    localparam int DW = 24;
    localparam int UW = 1;
    localparam int KW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    enable;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*UW-1:0] s_tuser;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    grant_o;
    logic            busy_o;
    logic [31:0]     frame_cnt;
    logic [15:0]     drop_cnt;

    always #5 clk = ~clk;

    axi4s_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .KEEP_WIDTH(KW)) m_if ();

    axis_frame_arbiter #(
        .N_SRC      (N),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .s_tvalid_i  (s_tvalid),
        .s_tready_o  (s_tready),
        .s_tdata_i   (s_tdata),
        .s_tuser_i   (s_tuser),
        .s_tlast_i   (s_tlast),
        .m_axis      (m_if),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt),
        .drop_cnt_o  (drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          last;
        logic [N-1:0]  grant;
    } exp_t;

    beat_t sq[N][$];
    exp_t  sb[$];
    int    checks    = 0;
    int    failures  = 0;
    int    beats_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int src, input int len,
                              input logic [DW-1:0] base, input bit expect_out);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            exp_t  e;
            x.data = base + DW'(b);
            x.sof  = (b == 0);
            x.last = (b == len - 1);
            sq[src].push_back(x);
            if (expect_out) begin
                e.data  = x.data;
                e.sof   = x.sof;
                e.last  = x.last;
                e.grant = N'(1 << src);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_raw(input int src, input logic [DW-1:0] data);
        beat_t x;
        x.data = data;
        x.sof  = 1'b0;
        x.last = 1'b0;
        sq[src].push_back(x);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int k = 0; k < N; k++) sq[k].delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((sb.size() != 0 || busy_o) && n < budget);
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    // source drivers and output monitor
    initial begin
        logic [N-1:0] hs;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            if (!rst && m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tdata", 32'(m_if.tdata), 32'(e.data));
                    chk("tuser", 32'(m_if.tuser), 32'(e.sof));
                    chk("tlast", 32'(m_if.tlast), 32'(e.last));
                    chk("grant", 32'(grant_o), 32'(e.grant));
                end
                beats_out++;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (!rst && hs[k] && sq[k].size() > 0) void'(sq[k].pop_front());
                if (sq[k].size() > 0) begin
                    s_tvalid[k]          = 1'b1;
                    s_tdata[k*DW +: DW]  = sq[k][0].data;
                    s_tuser[k]           = sq[k][0].sof;
                    s_tlast[k]           = sq[k][0].last;
                end else begin
                    s_tvalid[k]          = 1'b0;
                    s_tdata[k*DW +: DW]  = '0;
                    s_tuser[k]           = 1'b0;
                    s_tlast[k]           = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int nb;
        int first;
        int last;
        int b0;
        bit tog;

        rst         = 1'b1;
        enable      = 4'hF;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_frame", frame_cnt, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;

        // single 4-beat frame from src0
        push_frame(0, 4, 24'h000100, 1'b1);
        @(posedge clk);
        #2;
        chk("t1_arb_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("t1_arb_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #2;
        chk("t1_pass_busy", 32'(busy_o), 32'd1);
        chk("t1_pass_grant", 32'(grant_o), 32'd1);
        chk("t1_pass_tvalid", 32'(m_if.tvalid), 32'd1);
        chk("t1_tkeep", 32'(m_if.tkeep), 32'h7);
        chk("t1_tid_tdest", 32'({m_if.tid, m_if.tdest}), 32'd0);
        wait_drain("t1_drain", 50);
        chk("t1_frame_cnt", frame_cnt, 32'd1);

        // round robin across srcs 0..2
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) begin
                push_frame(s, 2, DW'(24'h100000 * (s + 1) + 24'h10 * r), 1'b1);
            end
        end
        n = 0; nb = 0; first = -1; last = -1;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (busy_o) begin
                nb++;
                if (first < 0) first = n;
                last = n;
            end
        end while ((sb.size() != 0 || busy_o || nb == 0) && n < 100);
        chk("rr_drain", 32'(n < 100), 32'd1);
        chk("rr_busy_cycles", 32'(nb), 32'd12);
        chk("rr_span", 32'(last - first + 1), 32'd17);
        chk("rr_frame_cnt", frame_cnt, 32'd6);

        // backpressure on src1
        do_reset();
        b0 = beats_out;
        push_frame(1, 5, 24'h200000, 1'b1);
        n = 0; tog = 1'b1;
        do begin
            @(posedge clk);
            #2;
            m_if.tready = tog;
            tog = ~tog;
            #1;
            n++;
            if (busy_o) begin
                chk("bp_src1_rdy", 32'(s_tready[1]), 32'(m_if.tready));
                chk("bp_other_rdy", 32'(s_tready & 4'b1101), 32'd0);
            end
        end while ((sb.size() != 0 || busy_o) && n < 100);
        m_if.tready = 1'b1;
        chk("bp_drain", 32'(n < 100), 32'd1);
        chk("bp_beats", 32'(beats_out - b0), 32'd5);
        chk("bp_frame_cnt", frame_cnt, 32'd1);

        // unaligned flush on src2 while src0 is granted
        do_reset();
        push_frame(0, 6, 24'h300000, 1'b1);
        push_raw(2, 24'hABC001);
        push_raw(2, 24'hABC002);
        push_raw(2, 24'hABC003);
        push_frame(2, 2, 24'h320000, 1'b1);
        wait_drain("fl_drain", 100);
        chk("fl_drop_cnt", 32'(drop_cnt), 32'd3);
        chk("fl_frame_cnt", frame_cnt, 32'd2);

        // enable mask and mid-frame disable
        do_reset();
        enable = 4'b1011;
        push_frame(2, 3, 24'h400000, 1'b0);
        push_frame(0, 4, 24'h410000, 1'b1);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (busy_o && beats_out > 0 && enable[0]) enable = 4'b1010;
            #1;
            chk("en_src2_rdy", 32'(s_tready[2]), 32'd0);
            chk("en_src2_grant", 32'(grant_o[2]), 32'd0);
        end while ((sb.size() != 0 || busy_o) && n < 100);
        chk("en_drain", 32'(n < 100), 32'd1);
        chk("en_enable_cleared", 32'(enable), 32'b1010);
        chk("en_frame_cnt", frame_cnt, 32'd1);
        repeat (5) @(posedge clk);
        #2;
        chk("en_idle_busy", 32'(busy_o), 32'd0);
        chk("en_idle_src2_rdy", 32'(s_tready[2]), 32'd0);

        // async reset mid-frame
        do_reset();
        enable = 4'hF;
        push_raw(1, 24'h5AA001);
        push_raw(1, 24'h5AA002);
        push_frame(0, 3, 24'h500000, 1'b1);
        wait_drain("rs_pre_drain", 50);
        chk("rs_pre_frame", frame_cnt, 32'd1);
        chk("rs_pre_drop", 32'(drop_cnt), 32'd2);
        b0 = beats_out;
        push_frame(0, 5, 24'h510000, 1'b1);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (beats_out - b0 < 2 && n < 50);
        chk("rs_reach_beat2", 32'(n < 50), 32'd1);
        rst = 1'b1;
        #1;
        chk("rs_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rs_grant", 32'(grant_o), 32'd0);
        chk("rs_busy", 32'(busy_o), 32'd0);
        chk("rs_frame", frame_cnt, 32'd0);
        chk("rs_drop", 32'(drop_cnt), 32'd0);
        for (int k = 0; k < N; k++) sq[k].delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rs_post_frame", frame_cnt, 32'd0);
        push_frame(0, 2, 24'h520000, 1'b1);
        push_frame(1, 2, 24'h530000, 1'b1);
        wait_drain("rs_post_drain", 50);
        chk("rs_post_frames", frame_cnt, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
